riscv_gshare_predictor: RTL and testbench

Parametrised gshare branch predictor with tagged BTB and speculative global history, for the IF stage of the 2 GHz RISC-V core.
- PHT of 2-bit saturating counters, indexed by PC XOR global history register (GHR).
- BTB is tagged and sized independently of the PHT.
- Fetch gets a same-cycle prediction plus a GHR snapshot; EX returns the snapshot on resolution for training and history recovery.

---
 rtl/riscv_gshare_predictor_if.sv | 32 +++
 rtl/riscv_gshare_predictor.sv | 128 ++++++++++++
 tb/tb_riscv_gshare_predictor.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_gshare_predictor_if.sv
// Fetch-lookup, branch-resolution and statistics signals of the gshare predictor.
interface riscv_gshare_predictor_if #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned GHR_BITS = 10
);
    logic                if_valid;
    logic [XLEN-1:0]     if_pc;
    logic                predict_hit;
    logic                predict_taken;
    logic [XLEN-1:0]     predict_target;
    logic [GHR_BITS-1:0] predict_ghr;
    logic                br_valid;
    logic [XLEN-1:0]     br_pc;
    logic                br_taken;
    logic [XLEN-1:0]     br_target;
    logic [GHR_BITS-1:0] br_ghr;
    logic                br_mispredict;
    logic [31:0]         stat_branches;
    logic [31:0]         stat_mispredicts;

    modport master (
        output if_valid, if_pc, br_valid, br_pc, br_taken, br_target, br_ghr, br_mispredict,
        input  predict_hit, predict_taken, predict_target, predict_ghr,
        input  stat_branches, stat_mispredicts
    );

    modport slave (
        input  if_valid, if_pc, br_valid, br_pc, br_taken, br_target, br_ghr, br_mispredict,
        output predict_hit, predict_taken, predict_target, predict_ghr,
        output stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/riscv_gshare_predictor.sv
// Gshare direction predictor with tagged BTB and speculative global history for IF.
// Define BP_STATS_EN to build the resolved-branch / mispredict statistics counters.
module riscv_gshare_predictor #(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned PHT_ENTRIES = 1024,
    parameter int unsigned BTB_ENTRIES = 256,
    parameter int unsigned GHR_BITS    = 10,
    parameter int unsigned TAG_BITS    = 12,
    parameter logic [1:0]  CTR_INIT    = 2'b01
) (
    input logic                    clk,
    input logic                    rst_n,
    riscv_gshare_predictor_if.slave bp
);
    localparam int unsigned P = $clog2(PHT_ENTRIES);
    localparam int unsigned B = $clog2(BTB_ENTRIES);

    logic [1:0]             pht_q        [PHT_ENTRIES];
    logic [BTB_ENTRIES-1:0] btb_valid_q;
    logic [TAG_BITS-1:0]    btb_tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]        btb_target_q [BTB_ENTRIES];
    logic [GHR_BITS-1:0]    ghr_q, ghr_d;

    logic [P-1:0]        if_pht_idx, br_pht_idx;
    logic [B-1:0]        if_btb_idx, br_btb_idx;
    logic [TAG_BITS-1:0] if_tag, br_tag;
    logic                hit, taken;
    logic [1:0]          ctr_cur, ctr_nxt;

    // History is zero-extended to the PHT index width before hashing.
    assign if_pht_idx = bp.if_pc[P+1:2] ^ P'(ghr_q);
    assign if_btb_idx = bp.if_pc[B+1:2];
    assign if_tag     = bp.if_pc[B+TAG_BITS+1:B+2];
    assign br_pht_idx = bp.br_pc[P+1:2] ^ P'(bp.br_ghr);
    assign br_btb_idx = bp.br_pc[B+1:2];
    assign br_tag     = bp.br_pc[B+TAG_BITS+1:B+2];

    logic unused_br_pc;
    assign unused_br_pc = ^bp.br_pc;

    always_comb begin
        hit   = btb_valid_q[if_btb_idx] && (btb_tag_q[if_btb_idx] == if_tag);
        taken = hit && pht_q[if_pht_idx][1];
    end

    assign bp.predict_hit    = hit;
    assign bp.predict_taken  = taken;
    assign bp.predict_target = taken ? btb_target_q[if_btb_idx] : bp.if_pc + XLEN'(4);
    assign bp.predict_ghr    = ghr_q;

    // Recovery from EX overrides the speculative shift from fetch.
    always_comb begin
        ghr_d = ghr_q;
        if (bp.br_valid && bp.br_mispredict) begin
            ghr_d = {bp.br_ghr[GHR_BITS-2:0], bp.br_taken};
        end else if (bp.if_valid && hit) begin
            ghr_d = {ghr_q[GHR_BITS-2:0], taken};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    always_comb begin
        ctr_cur = pht_q[br_pht_idx];
        if (bp.br_taken) begin
            ctr_nxt = (ctr_cur == 2'b11) ? ctr_cur : ctr_cur + 2'd1;
        end else begin
            ctr_nxt = (ctr_cur == 2'b00) ? ctr_cur : ctr_cur - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht_q[i] <= CTR_INIT;
            end
        end else if (bp.br_valid) begin
            pht_q[br_pht_idx] <= ctr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btb_valid_q <= '0;
        end else if (bp.br_valid && bp.br_taken) begin
            btb_valid_q[br_btb_idx] <= 1'b1;
        end
    end

    // Tag and target need no reset: the valid bit masks stale contents.
    always_ff @(posedge clk) begin
        if (bp.br_valid && bp.br_taken) begin
            btb_tag_q[br_btb_idx]    <= br_tag;
            btb_target_q[br_btb_idx] <= bp.br_target;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_br_q, stat_mis_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else if (bp.br_valid) begin
            if (stat_br_q != 32'hFFFF_FFFF) begin
                stat_br_q <= stat_br_q + 32'd1;
            end
            if (bp.br_mispredict && (stat_mis_q != 32'hFFFF_FFFF)) begin
                stat_mis_q <= stat_mis_q + 32'd1;
            end
        end
    end

    assign bp.stat_branches    = stat_br_q;
    assign bp.stat_mispredicts = stat_mis_q;
`else
    assign bp.stat_branches    = '0;
    assign bp.stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_riscv_gshare_predictor.sv
// Bench for riscv_gshare_predictor: table-level predictor model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_riscv_gshare_predictor;
    localparam int unsigned XLEN = 64;
    localparam int unsigned PHT  = 1024;
    localparam int unsigned BTB  = 256;
    localparam int unsigned GHRB = 10;
    localparam int unsigned TAGB = 12;
    localparam int unsigned BB   = $clog2(BTB);

    logic clk = 1'b0;
    logic rst_n;
    bit   chk_on = 1'b0;
    int   n_vec = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;

    riscv_gshare_predictor_if #(.XLEN(XLEN), .GHR_BITS(GHRB)) bp ();

    riscv_gshare_predictor #(
        .XLEN(XLEN), .PHT_ENTRIES(PHT), .BTB_ENTRIES(BTB),
        .GHR_BITS(GHRB), .TAG_BITS(TAGB), .CTR_INIT(2'b01)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bp(bp)
    );

    // Model state: plain integers per table entry.
    int unsigned       m_pht [PHT];
    bit                m_v   [BTB];
    longint unsigned   m_tag [BTB];
    longint unsigned   m_tgt [BTB];
    int unsigned       m_ghr, m_nbr, m_nmis;

    function automatic int unsigned pidx(longint unsigned pc, int unsigned g);
        longint unsigned gg = g;
        return int'(((pc >> 2) ^ gg) % PHT);
    endfunction

    function automatic int unsigned bidx(longint unsigned pc);
        return int'((pc >> 2) % BTB);
    endfunction

    function automatic longint unsigned tagof(longint unsigned pc);
        return (pc >> (2 + BB)) % (64'd1 << TAGB);
    endfunction

    function automatic bit m_hit(longint unsigned pc);
        return m_v[bidx(pc)] && (m_tag[bidx(pc)] == tagof(pc));
    endfunction

    function automatic bit m_taken(longint unsigned pc);
        return m_hit(pc) && (m_pht[pidx(pc, m_ghr)] >= 2);
    endfunction

    function automatic longint unsigned m_target(longint unsigned pc);
        return m_taken(pc) ? m_tgt[bidx(pc)] : pc + 64'd4;
    endfunction

    function automatic void reset_model();
        for (int i = 0; i < PHT; i++) m_pht[i] = 1;
        for (int i = 0; i < BTB; i++) begin
            m_v[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 0;
        end
        m_ghr = 0; m_nbr = 0; m_nmis = 0;
    endfunction

    // Advance the model by the clock edge that consumes the current inputs.
    function automatic void model_step();
        longint unsigned pc = bp.if_pc;
        bit h = m_hit(pc);
        bit t = m_taken(pc);
        int unsigned g = bp.br_ghr;
        int unsigned pi;
        if (bp.br_valid) begin
            pi = pidx(bp.br_pc, g);
            if (bp.br_taken) begin
                if (m_pht[pi] < 3) m_pht[pi] = m_pht[pi] + 1;
                m_v[bidx(bp.br_pc)]   = 1'b1;
                m_tag[bidx(bp.br_pc)] = tagof(bp.br_pc);
                m_tgt[bidx(bp.br_pc)] = bp.br_target;
            end else if (m_pht[pi] > 0) begin
                m_pht[pi] = m_pht[pi] - 1;
            end
            if (m_nbr != 32'hFFFF_FFFF) m_nbr++;
            if (bp.br_mispredict && m_nmis != 32'hFFFF_FFFF) m_nmis++;
        end
        if (bp.br_valid && bp.br_mispredict) m_ghr = ((g << 1) | int'(bp.br_taken)) % (1 << GHRB);
        else if (bp.if_valid && h) m_ghr = ((m_ghr << 1) | int'(t)) % (1 << GHRB);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge rst_n) reset_model();

    longint unsigned cpc;
    logic [31:0]     esb, esm;
    always @(negedge clk) begin
        if (chk_on) begin
            cpc = bp.if_pc;
`ifdef BP_STATS_EN
            esb = m_nbr; esm = m_nmis;
`else
            esb = 0; esm = 0;
`endif
            chk("hit", bp.predict_hit, m_hit(cpc));
            chk("taken", bp.predict_taken, m_taken(cpc));
            chk("target", bp.predict_target, m_target(cpc));
            chk("ghr", bp.predict_ghr, m_ghr);
            chk("stat_branches", bp.stat_branches, esb);
            chk("stat_mispredicts", bp.stat_mispredicts, esm);
            if (rst_n) model_step();
        end
    end

    task automatic apply(input bit iv, input longint unsigned ipc, input bit bv,
                         input longint unsigned bpc, input bit bt, input longint unsigned btg,
                         input int unsigned bg, input bit bm);
        @(posedge clk); #1;
        bp.if_valid = iv; bp.if_pc = ipc;
        bp.br_valid = bv; bp.br_pc = bpc; bp.br_taken = bt; bp.br_target = btg;
        bp.br_ghr = GHRB'(bg); bp.br_mispredict = bm;
        @(negedge clk); #1;
    endtask

    task automatic lookup(input longint unsigned pc);
        apply(1'b1, pc, 1'b0, 64'd0, 1'b0, 64'd0, 0, 1'b0);
    endtask

    task automatic resolve(input longint unsigned pc, input bit t, input longint unsigned tgt,
                           input int unsigned g, input bit m);
        apply(1'b0, 64'd0, 1'b1, pc, t, tgt, g, m);
    endtask

    task automatic idle();
        apply(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0, 0, 1'b0);
    endtask

    // Reset with a wrapping fetch PC so the reset-time target is 0.
    task automatic do_reset();
        @(posedge clk); #1;
        bp.if_valid = 1'b1; bp.if_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        bp.br_valid = 1'b0; bp.br_pc = '0; bp.br_taken = 1'b0; bp.br_target = '0;
        bp.br_ghr = '0; bp.br_mispredict = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk); #1;
        chk("rst_target_wrap", bp.predict_target, 64'd0);
        chk("rst_hit", bp.predict_hit, 1'b0);
        @(posedge clk); #2 rst_n = 1'b1;
    endtask

    initial begin
        bp.if_valid = 1'b0; bp.if_pc = '0; bp.br_valid = 1'b0; bp.br_pc = '0;
        bp.br_taken = 1'b0; bp.br_target = '0; bp.br_ghr = '0; bp.br_mispredict = 1'b0;
        reset_model();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        chk_on = 1'b1;
        @(posedge clk); #2 rst_n = 1'b1;

        // Cold lookup misses and leaves history alone.
        lookup(64'h1000);
        chk("t1_hit", bp.predict_hit, 1'b0);
        chk("t1_taken", bp.predict_taken, 1'b0);
        chk("t1_target", bp.predict_target, 64'h1004);
        idle();
        chk("t1_ghr", bp.predict_ghr, 10'd0);

        // Two taken resolutions train BTB and counter.
        resolve(64'h1000, 1'b1, 64'h2000, 0, 1'b0);
        resolve(64'h1000, 1'b1, 64'h2000, 0, 1'b0);
        lookup(64'h1000);
        chk("t2_hit", bp.predict_hit, 1'b1);
        chk("t2_taken", bp.predict_taken, 1'b1);
        chk("t2_target", bp.predict_target, 64'h2000);
        idle();
        chk("t2_ghr", bp.predict_ghr, 10'd1);

        // Same-cycle write and lookup of one entry: lookup sees the old entry.
        apply(1'b1, 64'h5000, 1'b1, 64'h5000, 1'b1, 64'h6000, 1, 1'b0);
        chk("rw_hit_old", bp.predict_hit, 1'b0);
        chk("rw_target_old", bp.predict_target, 64'h5004);
        lookup(64'h5000);
        chk("rw_hit_new", bp.predict_hit, 1'b1);
        chk("rw_target_new", bp.predict_target, 64'h6000);

        // Tag alias on the same BTB set misses.
        lookup(64'h1000 + 4 * BTB);
        chk("t5_hit", bp.predict_hit, 1'b0);
        chk("t5_target", bp.predict_target, 64'h1404);
        idle();
        chk("t5_ghr", bp.predict_ghr, 10'd3);

        // Saturation: 01->10->11->11->11->11 then down to 10, still taken.
        do_reset();
        for (int i = 0; i < 5; i++) resolve(64'h1000, 1'b1, 64'h2000, 0, 1'b0);
        resolve(64'h1000, 1'b0, 64'h0, 0, 1'b0);
        lookup(64'h1000);
        chk("t3_taken", bp.predict_taken, 1'b1);
        chk("t3_target", bp.predict_target, 64'h2000);
        lookup(64'h1000);
        chk("t3_ghr1_taken", bp.predict_taken, 1'b0);
        chk("t3_ghr1_target", bp.predict_target, 64'h1004);

        // Recovery beats a same-cycle speculative shift.
        for (int i = 0; i < 3; i++) lookup(64'h1000);
        apply(1'b1, 64'h1000, 1'b1, 64'h3000, 1'b0, 64'h0, 10'h2A, 1'b1);
        idle();
        chk("t4_ghr", bp.predict_ghr, 10'h054);

        // Mixed traffic checked only by the model.
        for (int i = 0; i < 24; i++) begin
            apply((i % 3) != 0, 64'h1000 + 4 * (i % 4), (i % 2) == 1,
                  64'h1000 + 4 * ((i + 1) % 4), (i % 5) < 3, 64'h8000 + 16 * i,
                  (7 * i) % 1024, (i % 7) == 3);
        end

        // Statistics: 7 resolutions, 3 mispredicted, then reset mid-run.
        do_reset();
        for (int i = 0; i < 7; i++) resolve(64'h2000 + 4 * i, i[0], 64'h9000, i, i % 2 == 1 && i < 6);
        idle();
`ifdef BP_STATS_EN
        chk("t6_branches", bp.stat_branches, 32'd7);
        chk("t6_mispredicts", bp.stat_mispredicts, 32'd3);
`else
        chk("t6_branches_tied", bp.stat_branches, 32'd0);
        chk("t6_mispredicts_tied", bp.stat_mispredicts, 32'd0);
`endif
        resolve(64'h2100, 1'b1, 64'hA000, 5, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_branches", bp.stat_branches, 32'd0);
        chk("t6_rst_mispredicts", bp.stat_mispredicts, 32'd0);
        chk("t6_rst_ghr", bp.predict_ghr, 10'd0);
        @(posedge clk); #1;
        chk("t6_rst_hold", bp.stat_branches, 32'd0);
        #1 rst_n = 1'b1;
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
